clasificador_conteo: RTL and testbench

//   Downstream of the Moore inspection FSM. Consumes its 2-bit verdict code E
//   (00 nada, 01 avanzar, 10 rechazado, 11 aprobado) and drives the line actuators:
//   a reject diverter pulse and an approval stamp pulse.

---
 rtl/clasificador_conteo.sv | 181 ++++++++++++++++++
 tb/tb_clasificador_conteo.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/clasificador_conteo.sv
`default_nettype none
// ============================================================================
// Module   : clasificador_conteo
// Purpose  : Consumes the 2-bit verdict code from the inspection FSM
//            (00 nada, 01 avanzar, 10 rechazado, 11 aprobado) and drives the
//            line actuators: a reject-diverter pulse and an approval-stamp
//            pulse. Tallies approved/rejected parts and raises a sticky alarm
//            after MAX_RECH consecutive rejects.
// Ports    : clk        in   rising-edge system clock
//            reset_n    in   asynchronous active-low reset
//            E          in   [1:0] verdict code
//            clr        in   synchronous clear (counters, run, alarm, FSM)
//            desvio     out  reject diverter active
//            sello      out  approval stamp active
//            alarma     out  sticky consecutive-reject alarm
//            aprob_cnt  out  [CNT_W-1:0] approved parts tally (saturating)
//            rech_cnt   out  [CNT_W-1:0] rejected parts tally (saturating)
// Revision : 1.0 - initial release
// ============================================================================
module clasificador_conteo #(
  parameter int CNT_W     = 8,
  parameter int PULSE_LEN = 4,
  parameter int MAX_RECH  = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       E,
  input  logic             clr,
  output logic             desvio,
  output logic             sello,
  output logic             alarma,
  output logic [CNT_W-1:0] aprob_cnt,
  output logic [CNT_W-1:0] rech_cnt
);

  localparam int TW = $clog2(PULSE_LEN + 1);
  localparam int RW = $clog2(MAX_RECH + 1);

  localparam logic [TW-1:0] T_LOAD   = TW'(PULSE_LEN - 1);
  localparam logic [RW-1:0] RUN_MAX  = RW'(MAX_RECH);
  localparam logic [RW-1:0] RUN_TRIP = RW'(MAX_RECH - 1);

  localparam logic [1:0] CODE_RECH  = 2'b10;
  localparam logic [1:0] CODE_APROB = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RECHAZO  = 2'd1,
    APROBADO = 2'd2,
    ALARMA   = 2'd3
  } state_t;

  state_t        state;
  logic [1:0]    e_q;
  logic [TW-1:0] timer;
  logic [RW-1:0] run_cnt;

  // Edge detection on the verdict code: a code held for several cycles is
  // a single part. A same-cycle clr swallows the event entirely.
  logic ev_r;
  logic ev_a;
  logic trip;

  assign ev_r = (E == CODE_RECH)  && (e_q != CODE_RECH)  && !clr;
  assign ev_a = (E == CODE_APROB) && (e_q != CODE_APROB) && !clr;

  // This reject completes the run; it beats the ordinary RECHAZO transition.
  assign trip = ev_r && (run_cnt >= RUN_TRIP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      e_q       <= 2'b00;
      timer     <= '0;
      run_cnt   <= '0;
      aprob_cnt <= '0;
      rech_cnt  <= '0;
      desvio    <= 1'b0;
      sello     <= 1'b0;
      alarma    <= 1'b0;
    end else begin
      // The code history keeps tracking E even through clr, so a code held
      // across clr is not seen as a fresh event afterwards.
      e_q <= E;

      if (clr) begin
        state     <= IDLE;
        timer     <= '0;
        run_cnt   <= '0;
        aprob_cnt <= '0;
        rech_cnt  <= '0;
        desvio    <= 1'b0;
        sello     <= 1'b0;
        alarma    <= 1'b0;
      end else begin
        // Saturating tallies
        if (ev_a && (aprob_cnt != {CNT_W{1'b1}})) aprob_cnt <= aprob_cnt + 1'b1;
        if (ev_r && (rech_cnt  != {CNT_W{1'b1}})) rech_cnt  <= rech_cnt + 1'b1;

        // Consecutive-reject run, saturating at MAX_RECH
        if (ev_a) begin
          run_cnt <= '0;
        end else if (ev_r && (run_cnt != RUN_MAX)) begin
          run_cnt <= run_cnt + 1'b1;
        end

        if (trip) begin
          state  <= ALARMA;
          timer  <= '0;
          desvio <= 1'b1;
          sello  <= 1'b0;
          alarma <= 1'b1;
        end else begin
          case (state)
            IDLE: begin
              if (ev_r) begin
                state  <= RECHAZO;
                timer  <= T_LOAD;
                desvio <= 1'b1;
                sello  <= 1'b0;
              end else if (ev_a) begin
                state  <= APROBADO;
                timer  <= T_LOAD;
                desvio <= 1'b0;
                sello  <= 1'b1;
              end
            end

            RECHAZO: begin
              if (ev_a) begin
                state  <= APROBADO;
                timer  <= T_LOAD;
                desvio <= 1'b0;
                sello  <= 1'b1;
              end else if (ev_r) begin
                timer <= T_LOAD;
              end else if (timer == '0) begin
                state  <= IDLE;
                desvio <= 1'b0;
              end else begin
                timer <= timer - 1'b1;
              end
            end

            APROBADO: begin
              if (ev_r) begin
                state  <= RECHAZO;
                timer  <= T_LOAD;
                desvio <= 1'b1;
                sello  <= 1'b0;
              end else if (ev_a) begin
                timer <= T_LOAD;
              end else if (timer == '0) begin
                state <= IDLE;
                sello <= 1'b0;
              end else begin
                timer <= timer - 1'b1;
              end
            end

            // Sticky: only clr or reset leave; outputs are already held.
            ALARMA: begin
              desvio <= 1'b1;
              sello  <= 1'b0;
              alarma <= 1'b1;
            end

            default: begin
              state  <= IDLE;
              desvio <= 1'b0;
              sello  <= 1'b0;
              alarma <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clasificador_conteo.sv
`default_nettype none
// ============================================================================
// Module   : tb_clasificador_conteo
// Purpose  : Directed self-checking bench for clasificador_conteo. A second
//            instance with CNT_W=2 exercises counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clasificador_conteo;

  logic       clk;
  logic       reset_n;
  logic [1:0] E;
  logic       clr;
  logic       desvio, sello, alarma;
  logic [7:0] aprob_cnt, rech_cnt;
  logic       desvio2, sello2, alarma2;
  logic [1:0] aprob_cnt2, rech_cnt2;

  int n_cmp;
  int n_fail;

  clasificador_conteo #(.CNT_W(8), .PULSE_LEN(4), .MAX_RECH(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .E         (E),
    .clr       (clr),
    .desvio    (desvio),
    .sello     (sello),
    .alarma    (alarma),
    .aprob_cnt (aprob_cnt),
    .rech_cnt  (rech_cnt)
  );

  clasificador_conteo #(.CNT_W(2), .PULSE_LEN(4), .MAX_RECH(3)) dut_small (
    .clk       (clk),
    .reset_n   (reset_n),
    .E         (E),
    .clr       (clr),
    .desvio    (desvio2),
    .sello     (sello2),
    .alarma    (alarma2),
    .aprob_cnt (aprob_cnt2),
    .rech_cnt  (rech_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive E/clr on the falling edge, let the rising edge sample, look 1 ns later.
  task automatic step(input logic [1:0] e, input logic c);
    @(negedge clk);
    E   = e;
    clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag, input logic d, input logic s, input logic a);
    check({tag, ".desvio"}, 32'(desvio), 32'(d));
    check({tag, ".sello"},  32'(sello),  32'(s));
    check({tag, ".alarma"}, 32'(alarma), 32'(a));
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    E       = 2'b00;
    clr     = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    outs("reset", 1'b0, 1'b0, 1'b0);
    check("reset.aprob", 32'(aprob_cnt), 32'd0);
    check("reset.rech",  32'(rech_cnt),  32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: asynchronous reset in the middle of a reject pulse
    step(2'b10, 1'b0);
    outs("t1.pulse", 1'b1, 1'b0, 1'b0);
    check("t1.rech", 32'(rech_cnt), 32'd1);
    #2;
    reset_n = 1'b0;
    E       = 2'b00;
    #1;
    outs("t1.async", 1'b0, 1'b0, 1'b0);
    check("t1.async.rech", 32'(rech_cnt), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step(2'b00, 1'b0);
    outs("t1.idle", 1'b0, 1'b0, 1'b0);

    // 2: single approval -> stamp for exactly 4 cycles
    step(2'b01, 1'b0);
    outs("t2.avanzar", 1'b0, 1'b0, 1'b0);
    step(2'b11, 1'b0);
    outs("t2.c1", 1'b0, 1'b1, 1'b0);
    check("t2.aprob", 32'(aprob_cnt), 32'd1);
    step(2'b00, 1'b0);
    outs("t2.c2", 1'b0, 1'b1, 1'b0);
    step(2'b00, 1'b0);
    outs("t2.c3", 1'b0, 1'b1, 1'b0);
    step(2'b00, 1'b0);
    outs("t2.c4", 1'b0, 1'b1, 1'b0);
    step(2'b00, 1'b0);
    outs("t2.end", 1'b0, 1'b0, 1'b0);
    check("t2.aprob_end", 32'(aprob_cnt), 32'd1);

    // 3: held reject code counts once
    step(2'b10, 1'b0);
    check("t3.d1", 32'(desvio), 32'd1);
    step(2'b10, 1'b0);
    check("t3.d2", 32'(desvio), 32'd1);
    step(2'b10, 1'b0);
    check("t3.d3", 32'(desvio), 32'd1);
    check("t3.rech", 32'(rech_cnt), 32'd1);
    step(2'b00, 1'b0);
    check("t3.d4", 32'(desvio), 32'd1);
    step(2'b00, 1'b0);
    check("t3.d5", 32'(desvio), 32'd0);

    // 4: three isolated rejects trip the alarm
    step(2'b00, 1'b1);
    check("t4.clr.aprob", 32'(aprob_cnt), 32'd0);
    check("t4.clr.rech",  32'(rech_cnt),  32'd0);
    step(2'b10, 1'b0);
    step(2'b00, 1'b0);
    step(2'b10, 1'b0);
    outs("t4.second", 1'b1, 1'b0, 1'b0);
    step(2'b00, 1'b0);
    step(2'b10, 1'b0);
    outs("t4.trip", 1'b1, 1'b0, 1'b1);
    check("t4.rech", 32'(rech_cnt), 32'd3);
    repeat (5) step(2'b00, 1'b0);
    outs("t4.held", 1'b1, 1'b0, 1'b1);
    step(2'b11, 1'b0);
    outs("t4.aprob_in_alarm", 1'b1, 1'b0, 1'b1);
    check("t4.aprob", 32'(aprob_cnt), 32'd1);
    step(2'b00, 1'b1);
    outs("t4.clr", 1'b0, 1'b0, 1'b0);
    check("t4.clr2.aprob", 32'(aprob_cnt), 32'd0);
    check("t4.clr2.rech",  32'(rech_cnt),  32'd0);

    // 5: reject then approval two cycles later
    step(2'b10, 1'b0);
    outs("t5.r", 1'b1, 1'b0, 1'b0);
    step(2'b00, 1'b0);
    step(2'b11, 1'b0);
    outs("t5.swap", 1'b0, 1'b1, 1'b0);
    step(2'b00, 1'b0);
    step(2'b00, 1'b0);
    step(2'b00, 1'b0);
    outs("t5.s4", 1'b0, 1'b1, 1'b0);
    step(2'b00, 1'b0);
    outs("t5.end", 1'b0, 1'b0, 1'b0);
    // Run was zeroed by the approval: two more rejects must not alarm
    step(2'b10, 1'b0);
    step(2'b00, 1'b0);
    step(2'b10, 1'b0);
    check("t5.no_alarm", 32'(alarma), 32'd0);
    check("t5.rech", 32'(rech_cnt), 32'd3);
    // clr together with a fresh approval drops the event
    step(2'b11, 1'b1);
    outs("t5.clr_ev", 1'b0, 1'b0, 1'b0);
    check("t5.clr_ev.aprob", 32'(aprob_cnt), 32'd0);
    step(2'b11, 1'b0);
    check("t5.held_after_clr", 32'(aprob_cnt), 32'd0);
    check("t5.held_after_clr.sello", 32'(sello), 32'd0);

    // 6: saturation of a 2-bit tally
    step(2'b00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(2'b11, 1'b0);
      step(2'b00, 1'b0);
    end
    check("t6.aprob8", 32'(aprob_cnt),  32'd5);
    check("t6.aprob2", 32'(aprob_cnt2), 32'd3);
    check("t6.rech2",  32'(rech_cnt2),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
